spart_bus_ctrl: RTL and testbench
=================================

Name: spart_bus_ctrl

Overview:
Processor-facing controller for the SPART serial port. Decodes iocs/iorw/ioaddr bus cycles and holds the 16-bit baud divisor. Generates the baud enable tick shared by the receive and transmit units. Sequences transmit loads against the transmitter's busy/done handshake, and buffers received bytes with ready and overrun status.

Parameters:
DIV_W, 16, width of baud divisor and counter
DEFAULT_DIV, 16'd162, divisor value after reset (50 MHz, 19200 baud, x16 oversample)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
iocs  input  1  chip select for the bus cycle
iorw  input  1  1 = processor read, 0 = processor write
ioaddr  input  2  00 data buffer, 01 status, 10 divisor low, 11 divisor high
bus_wdata  input  8  processor write data
bus_rdata  output  8  processor read data
bus_rdata_oe  output  1  drive enable for the shared databus; equals iocs & iorw
rda  output  1  receive data available
tbr  output  1  transmit buffer ready
baud_en  output  1  one-cycle baud tick to the rx/tx units
tx_data  output  8  byte handed to the transmitter
tx_load  output  1  one-cycle pulse: transmitter captures tx_data
tx_done  input  1  one-cycle pulse: transmitter finished the stop bit
rx_data  input  8  byte from the receive shifter
rx_valid  input  1  one-cycle pulse: rx_data is a complete byte

Behaviour:
- Reset values:
  - divisor = DEFAULT_DIV; baud counter = DEFAULT_DIV
  - baud_en = 0, tx_load = 0, tx_data = 0, rx buffer = 0
  - rda = 0, tbr = 1, rx_ovr = 0, tx_ovr = 0
  - tx FSM = IDLE
- Reset mid-operation returns all of the above immediately. An in-flight tx_load is dropped.
- Write decode (iocs & ~iorw), captured on the clock edge:
  - 00: transmit request (see tx FSM)
  - 10: divisor[7:0] = bus_wdata
  - 11: divisor[15:8] = bus_wdata
  - 01: ignored
- Read decode (iocs & iorw) is combinational, bus_rdata = 0 when not reading:
  - 00: rx buffer
  - 01: {4'b0, tx_ovr, rx_ovr, tbr, rda}
  - 10: divisor low byte
  - 11: divisor high byte
- Baud generator:
  - Down counter. When it reaches 0: baud_en = 1 for that cycle, counter reloads with the divisor.
  - Any divisor write reloads the counter with the new value on the cycle after the write.
  - Divisor value 0 is treated as 1, so baud_en is high every other cycle, never stuck.
- tx FSM, states IDLE / LOAD / BUSY:
  - IDLE + data write: tx_data = bus_wdata, next state LOAD, tbr = 0.
  - LOAD: tx_load = 1 for exactly one cycle, next state BUSY.
  - BUSY + tx_done: next state IDLE, tbr = 1 on the following cycle.
  - Data write in LOAD or BUSY: byte discarded, tx_ovr set (sticky), state unchanged.
  - tx_done outside BUSY: ignored.
- Receive buffering:
  - rx_valid: rx buffer = rx_data, rda = 1.
  - rx_valid while rda = 1: overwrite the buffer, set rx_ovr (sticky).
  - Read of 00: rda = 0 on the next cycle.
  - rx_valid in the same cycle as a read of 00: the new byte is kept, rda stays 1, no overrun. The read returns the old byte.
- Status read (addr 01) clears rx_ovr and tx_ovr on the next cycle. A set event in the same cycle wins over the clear.

Decomposition:
- Package spart_pkg holds:
  - ioaddr constants ADDR_DATA, ADDR_STATUS, ADDR_DBL, ADDR_DBH
  - tx_state_t enum {IDLE, LOAD, BUSY}
  - status bit index constants
- Sub-module spart_baud_gen: divisor in, reload strobe in, baud_en out. It is the only natural split; the tx FSM and rx buffer stay in the top.

Test Plan:
- Reset, then read status and divisor:
  - status = 8'h02; divisor reads 8'hA2 and 8'h00
  - baud_en first pulses 162 cycles after reset release, then every 163 cycles.
- Write DBL = 8'h04, DBH = 8'h00:
  - baud_en period becomes 5 cycles starting after the reload.
  - Then write DBL = 8'h00: baud_en high every other cycle.
- Write data 8'h55 with tbr = 1:
  - tbr falls the next cycle; tx_load pulses once with tx_data = 8'h55.
  - Write 8'hAA while BUSY: tx_data stays 8'h55, status bit3 = 1.
  - Pulse tx_done: tbr returns to 1.
  - Status read returns 8'h0A and clears bit3.
- Pulse rx_valid with 8'h3C:
  - rda = 1; read 00 returns 8'h3C; rda = 0 next cycle.
  - Pulse 8'h11 then 8'h22 with no read: buffer = 8'h22, status = 8'h07.
- rx_valid (8'h99) in the same cycle as a read of 00 holding 8'h3C:
  - Read returns 8'h3C; rda stays 1; rx_ovr stays 0; the next read returns 8'h99.
- Assert rst during BUSY with rda = 1 and rx_ovr = 1:
  - All outputs return to reset values asynchronously, including tbr = 1 and rda = 0.
  - No tx_load pulse after release.

Source files
------------

// File: rtl/spart_pkg.sv
// Shared SPART bus-controller definitions: register addresses,
// transmit sequencer states and status-register bit positions.
package spart_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DBL    = 2'b10;
    localparam logic [1:0] ADDR_DBH    = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        BUSY = 2'd2
    } tx_state_t;

    localparam int STAT_RDA    = 0;
    localparam int STAT_TBR    = 1;
    localparam int STAT_RX_OVR = 2;
    localparam int STAT_TX_OVR = 3;

endpackage

// File: rtl/spart_baud_gen.sv
// Baud tick generator: down counter that pulses baud_en at zero and
// reloads from the divisor; a zero divisor behaves as one.
module spart_baud_gen #(
    parameter int               DIV_W       = 16,
    parameter logic [DIV_W-1:0] DEFAULT_DIV = 16'd162
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] divisor,
    input  logic             reload,
    output logic             baud_en
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_eff;

    assign div_eff = (divisor == '0) ? DIV_W'(1) : divisor;
    assign baud_en = (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= DEFAULT_DIV;
        end else if (reload || (cnt == '0)) begin
            cnt <= div_eff;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/spart_bus_ctrl.sv
// SPART processor-side controller: bus decode, baud divisor, transmit
// load sequencing and receive buffering with overrun status.
module spart_bus_ctrl
    import spart_pkg::*;
#(
    parameter int               DIV_W       = 16,
    parameter logic [DIV_W-1:0] DEFAULT_DIV = 16'd162
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    input  logic [7:0] bus_wdata,
    output logic [7:0] bus_rdata,
    output logic       bus_rdata_oe,
    output logic       rda,
    output logic       tbr,
    output logic       baud_en,
    output logic [7:0] tx_data,
    output logic       tx_load,
    input  logic       tx_done,
    input  logic [7:0] rx_data,
    input  logic       rx_valid
);

    logic             wr, rd;
    logic             wr_data, wr_dbl, wr_dbh, rd_data, rd_status;
    logic [DIV_W-1:0] divisor;
    logic             div_reload;
    logic [7:0]       rx_buf;
    logic             rx_ovr, tx_ovr;
    logic [7:0]       status;
    tx_state_t        state, next_state;

    assign wr        = iocs & ~iorw;
    assign rd        = iocs & iorw;
    assign wr_data   = wr && (ioaddr == ADDR_DATA);
    assign wr_dbl    = wr && (ioaddr == ADDR_DBL);
    assign wr_dbh    = wr && (ioaddr == ADDR_DBH);
    assign rd_data   = rd && (ioaddr == ADDR_DATA);
    assign rd_status = rd && (ioaddr == ADDR_STATUS);
    assign bus_rdata_oe = rd;

    // The counter picks up a new divisor one cycle after the write lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            divisor    <= DEFAULT_DIV;
            div_reload <= 1'b0;
        end else begin
            if (wr_dbl) divisor[7:0]  <= bus_wdata;
            if (wr_dbh) divisor[15:8] <= bus_wdata;
            div_reload <= wr_dbl | wr_dbh;
        end
    end

    spart_baud_gen #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_baud_gen (
        .clk     (clk),
        .rst     (rst),
        .divisor (divisor),
        .reload  (div_reload),
        .baud_en (baud_en)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        tx_load    = 1'b0;
        tbr        = 1'b0;
        case (state)
            IDLE: begin
                tbr = 1'b1;
                if (wr_data) next_state = LOAD;
            end
            LOAD: begin
                tx_load    = 1'b1;
                next_state = BUSY;
            end
            BUSY: begin
                if (tx_done) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Overrun flags are sticky; a set in the same cycle as a status read wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_data <= '0;
            tx_ovr  <= 1'b0;
            rx_buf  <= '0;
            rda     <= 1'b0;
            rx_ovr  <= 1'b0;
        end else begin
            if (wr_data && (state == IDLE)) tx_data <= bus_wdata;

            if (wr_data && (state != IDLE)) tx_ovr <= 1'b1;
            else if (rd_status)             tx_ovr <= 1'b0;

            if (rx_valid) rx_buf <= rx_data;

            if (rx_valid)     rda <= 1'b1;
            else if (rd_data) rda <= 1'b0;

            if (rx_valid && rda && !rd_data) rx_ovr <= 1'b1;
            else if (rd_status)              rx_ovr <= 1'b0;
        end
    end

    always_comb begin
        status              = '0;
        status[STAT_RDA]    = rda;
        status[STAT_TBR]    = tbr;
        status[STAT_RX_OVR] = rx_ovr;
        status[STAT_TX_OVR] = tx_ovr;
    end

    always_comb begin
        bus_rdata = '0;
        if (rd) begin
            case (ioaddr)
                ADDR_DATA:   bus_rdata = rx_buf;
                ADDR_STATUS: bus_rdata = status;
                ADDR_DBL:    bus_rdata = divisor[7:0];
                default:     bus_rdata = divisor[15:8];
            endcase
        end
    end

endmodule

// File: tb/tb_spart_bus_ctrl.sv
// Self-checking bench for spart_bus_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a model.
`timescale 1ns/1ps
module tb_spart_bus_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       iocs, iorw;
    logic [1:0] ioaddr;
    logic [7:0] bus_wdata, bus_rdata;
    logic       bus_rdata_oe, rda, tbr, baud_en;
    logic [7:0] tx_data;
    logic       tx_load, tx_done;
    logic [7:0] rx_data;
    logic       rx_valid;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spart_bus_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .iocs         (iocs),
        .iorw         (iorw),
        .ioaddr       (ioaddr),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata),
        .bus_rdata_oe (bus_rdata_oe),
        .rda          (rda),
        .tbr          (tbr),
        .baud_en      (baud_en),
        .tx_data      (tx_data),
        .tx_load      (tx_load),
        .tx_done      (tx_done),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Baud ticks are tracked as an absolute schedule (next tick cycle),
    // with divisor writes taking effect two cycles after they are presented.
    int         n, next_tick, m_load_at;
    int         rq_t[$];
    int         rq_e[$];
    logic [15:0] m_div;
    bit         m_idle, m_rda, m_rxovr, m_txovr;
    logic [7:0] m_txd, m_rxbuf;

    function automatic int eff(input logic [15:0] d);
        return (d == 16'd0) ? 1 : int'(d);
    endfunction

    always @(negedge clk) begin : cmp
        logic [7:0] exp_rd, st;
        bit exp_baud, wr, rd, rd0, rds, rxset, txset, done_ok;
        if (rst) begin
            n = 0; next_tick = 162; m_div = 16'd162;
            rq_t.delete(); rq_e.delete();
            m_idle = 1; m_load_at = -10; m_txd = 8'h00; m_rxbuf = 8'h00;
            m_rda = 0; m_rxovr = 0; m_txovr = 0;
        end
        while (rq_t.size() > 0 && rq_t[0] == n) begin
            next_tick = n + rq_e[0];
            rq_t.delete(0);
            rq_e.delete(0);
        end
        exp_baud = (n == next_tick);
        if (exp_baud) next_tick = n + eff(m_div) + 1;

        wr  = iocs && !iorw;
        rd  = iocs && iorw;
        rd0 = rd && (ioaddr == 2'd0);
        rds = rd && (ioaddr == 2'd1);
        st  = {4'b0, m_txovr, m_rxovr, m_idle, m_rda};
        case (ioaddr)
            2'd0: exp_rd = m_rxbuf;
            2'd1: exp_rd = st;
            2'd2: exp_rd = m_div[7:0];
            default: exp_rd = m_div[15:8];
        endcase
        if (!rd) exp_rd = 8'h00;

        chk("cyc_baud_en", baud_en, exp_baud);
        chk("cyc_tbr", tbr, m_idle);
        chk("cyc_rda", rda, m_rda);
        chk("cyc_tx_load", tx_load, (n == m_load_at));
        chk("cyc_tx_data", tx_data, m_txd);
        chk("cyc_rdata", bus_rdata, exp_rd);
        chk("cyc_rdata_oe", bus_rdata_oe, rd);

        if (!rst) begin
            done_ok = tx_done && !m_idle && (n > m_load_at);
            txset = 0;
            if (wr && ioaddr == 2'd0) begin
                if (m_idle) begin
                    m_txd = bus_wdata; m_idle = 0; m_load_at = n + 1;
                end else begin
                    txset = 1;
                end
            end
            if (done_ok) m_idle = 1;
            if (wr && ioaddr == 2'd2) begin
                m_div[7:0] = bus_wdata; rq_t.push_back(n + 2); rq_e.push_back(eff(m_div));
            end
            if (wr && ioaddr == 2'd3) begin
                m_div[15:8] = bus_wdata; rq_t.push_back(n + 2); rq_e.push_back(eff(m_div));
            end
            rxset = rx_valid && m_rda && !rd0;
            if (rx_valid) begin
                m_rxbuf = rx_data; m_rda = 1;
            end else if (rd0) begin
                m_rda = 0;
            end
            m_rxovr = rxset ? 1'b1 : (rds ? 1'b0 : m_rxovr);
            m_txovr = txset ? 1'b1 : (rds ? 1'b0 : m_txovr);
        end
        n++;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
        iocs = 1; iorw = 0; ioaddr = a; bus_wdata = d;
        tick();
        iocs = 0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [7:0] v);
        iocs = 1; iorw = 1; ioaddr = a;
        #2 v = bus_rdata;
        tick();
        iocs = 0;
    endtask

    task automatic pulse_rx(input logic [7:0] d);
        rx_data = d; rx_valid = 1;
        tick();
        rx_valid = 0;
    endtask

    task automatic wait_pulse(output int k, input int limit);
        k = 0;
        do begin
            tick();
            k++;
        end while (!baud_en && k < limit);
    endtask

    initial begin : stim
        int k, loads;
        logic [7:0] v;
        rst = 1; iocs = 0; iorw = 0; ioaddr = 0; bus_wdata = 0;
        tx_done = 0; rx_data = 0; rx_valid = 0;
        repeat (3) @(negedge clk);
        #1 rst = 0;

        wait_pulse(k, 400); chk("first_baud_delay", k, 162);
        wait_pulse(k, 400); chk("baud_period_default", k, 163);
        bus_rd(2'd1, v); chk("reset_status", v, 8'h02);
        bus_rd(2'd2, v); chk("reset_dbl", v, 8'hA2);
        bus_rd(2'd3, v); chk("reset_dbh", v, 8'h00);

        bus_wr(2'd2, 8'h04);
        bus_wr(2'd3, 8'h00);
        wait_pulse(k, 400);
        wait_pulse(k, 400); chk("baud_period_div4", k, 5);
        bus_wr(2'd2, 8'h00);
        wait_pulse(k, 400);
        wait_pulse(k, 400); chk("baud_period_div0", k, 2);

        chk("tbr_idle", tbr, 1'b1);
        bus_wr(2'd0, 8'h55);
        chk("tbr_fall", tbr, 1'b0);
        chk("tx_load_pulse", tx_load, 1'b1);
        chk("tx_data_55", tx_data, 8'h55);
        tick();
        chk("tx_load_single", tx_load, 1'b0);
        bus_wr(2'd0, 8'hAA);
        chk("tx_data_kept", tx_data, 8'h55);
        tx_done = 1; tick(); tx_done = 0;
        chk("tbr_return", tbr, 1'b1);
        bus_rd(2'd1, v); chk("status_tx_ovr", v, 8'h0A);
        bus_rd(2'd1, v); chk("status_cleared", v, 8'h02);

        pulse_rx(8'h3C);
        chk("rda_set", rda, 1'b1);
        bus_rd(2'd0, v); chk("rx_read_3c", v, 8'h3C);
        chk("rda_clear", rda, 1'b0);
        pulse_rx(8'h11);
        pulse_rx(8'h22);
        bus_rd(2'd1, v); chk("status_rx_ovr", v, 8'h07);
        bus_rd(2'd0, v); chk("rx_read_22", v, 8'h22);
        pulse_rx(8'h3C);
        iocs = 1; iorw = 1; ioaddr = 2'd0; rx_data = 8'h99; rx_valid = 1;
        #2 v = bus_rdata;
        tick();
        iocs = 0; rx_valid = 0;
        chk("rx_same_cycle_old", v, 8'h3C);
        chk("rx_same_cycle_rda", rda, 1'b1);
        bus_rd(2'd1, v); chk("rx_same_cycle_no_ovr", v, 8'h03);
        bus_rd(2'd0, v); chk("rx_same_cycle_new", v, 8'h99);

        for (int i = 0; i < 4000; i++) begin
            iocs      = ($urandom_range(0, 3) == 0);
            iorw      = 1'($urandom_range(0, 1));
            ioaddr    = 2'($urandom_range(0, 3));
            bus_wdata = 8'($urandom);
            if (ioaddr == 2'd2) bus_wdata = 8'($urandom_range(0, 15));
            if (ioaddr == 2'd3) bus_wdata = 8'h00;
            rx_valid  = ($urandom_range(0, 7) == 0);
            rx_data   = 8'($urandom);
            tx_done   = ($urandom_range(0, 5) == 0);
            tick();
        end
        iocs = 0; rx_valid = 0;

        tx_done = 1; repeat (3) tick(); tx_done = 0;
        bus_wr(2'd0, 8'h5A);
        tick();
        pulse_rx(8'h01);
        pulse_rx(8'h02);
        chk("pre_reset_busy", tbr, 1'b0);
        chk("pre_reset_rda", rda, 1'b1);
        #2 rst = 1;
        #1;
        chk("async_rst_tbr", tbr, 1'b1);
        chk("async_rst_rda", rda, 1'b0);
        chk("async_rst_tx_load", tx_load, 1'b0);
        chk("async_rst_tx_data", tx_data, 8'h00);
        chk("async_rst_baud_en", baud_en, 1'b0);
        iocs = 1; iorw = 1; ioaddr = 2'd1;
        #1 chk("async_rst_status", bus_rdata, 8'h02);
        iocs = 0;
        repeat (2) @(negedge clk);
        #1 rst = 0;
        loads = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (tx_load) loads++;
        end
        chk("no_load_after_reset", loads, 0);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
